// File: rtl/ws_pkg.sv
// Shared definitions for the weight-stationary array controller:
// FSM encoding, default array geometry and a width helper.
package ws_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ARRAY_SIZE = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WLOAD = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } ws_state_e;

    // Bits needed to index 0..value-1; never less than 1.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return (res < 1) ? 1 : res;
    endfunction

endpackage

// File: rtl/ws_window_gen.sv
// Registered window detector: high while base <= cnt < base + num and enabled.
module ws_window_gen #(
    parameter int CW    = 9,
    parameter int LEN_W = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic [CW-1:0] cnt,
    input  logic [CW-1:0] base,
    input  logic [LEN_W-1:0] num,
    output logic          in_window
);

    logic [CW-1:0] limit;

    // Cannot overflow: base <= 2N and 2N <= 2^LEN_W keep base + num below 2^CW.
    assign limit = base + CW'(num);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_window <= 1'b0;
        end else begin
            in_window <= en && (cnt >= base) && (cnt < limit);
        end
    end

endmodule

// File: rtl/ws_array_controller.sv
// Sequencer for an N x N weight-stationary PE array: loads one weight tile,
// then streams M fmap vectors with per-row skew enables and per-column valids.
module ws_array_controller
    import ws_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
    parameter int LEN_W      = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         i_start,
    input  logic [LEN_W-1:0]             i_num_vec,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_wgt_rd_en,
    output logic [clog2(ARRAY_SIZE)-1:0] o_wgt_addr,
    output logic                         o_load,
    output logic                         o_fmap_rd_en,
    output logic [LEN_W-1:0]             o_fmap_addr,
    output logic [ARRAY_SIZE-1:0]        o_row_en,
    output logic [ARRAY_SIZE-1:0]        o_col_valid
);

    localparam int AW = clog2(ARRAY_SIZE);
    localparam int WW = clog2(ARRAY_SIZE + 1);
    localparam int CW = LEN_W + 1;
    localparam logic [WW-1:0] W_LAST = WW'(ARRAY_SIZE);
    localparam logic [CW-1:0] TAIL   = CW'(2 * ARRAY_SIZE - 1);

    if (ARRAY_SIZE < 2 || DATA_WIDTH < 1 || (2 * ARRAY_SIZE) > (1 << LEN_W)) begin : g_param_check
        $error("ws_array_controller: unsupported ARRAY_SIZE/LEN_W/DATA_WIDTH combination");
    end

    ws_state_e        state, state_nxt;
    logic [WW-1:0]    w, w_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [LEN_W-1:0] num, num_nxt;
    logic             busy_d, done_d, wgt_rd_en_d, load_d, fmap_rd_en_d;
    logic [AW-1:0]    wgt_addr_d;
    logic [LEN_W-1:0] fmap_addr_d;
    logic             run;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_nxt    = state;
        w_nxt        = w;
        cnt_nxt      = cnt;
        num_nxt      = num;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        wgt_rd_en_d  = 1'b0;
        wgt_addr_d   = '0;
        load_d       = 1'b0;
        fmap_rd_en_d = 1'b0;
        fmap_addr_d  = '0;
        case (state)
            // o_done is visible while already back in IDLE; a start then is still ignored.
            S_IDLE: begin
                if (i_start && !o_done) begin
                    num_nxt   = i_num_vec;
                    w_nxt     = '0;
                    state_nxt = S_WLOAD;
                end
            end
            S_WLOAD: begin
                busy_d = 1'b1;
                load_d = (w != '0);
                if (w != W_LAST) begin
                    wgt_rd_en_d = 1'b1;
                    wgt_addr_d  = AW'(W_LAST - w - WW'(1));
                    w_nxt       = w + WW'(1);
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = (num == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy_d = 1'b1;
                if (cnt < CW'(num)) begin
                    fmap_rd_en_d = 1'b1;
                    fmap_addr_d  = cnt[LEN_W-1:0];
                end
                if (cnt == CW'(num) + TAIL) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_DONE: begin
                done_d    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            w            <= '0;
            cnt          <= '0;
            num          <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_wgt_rd_en  <= 1'b0;
            o_wgt_addr   <= '0;
            o_load       <= 1'b0;
            o_fmap_rd_en <= 1'b0;
            o_fmap_addr  <= '0;
        end else begin
            state        <= state_nxt;
            w            <= w_nxt;
            cnt          <= cnt_nxt;
            num          <= num_nxt;
            o_busy       <= busy_d;
            o_done       <= done_d;
            o_wgt_rd_en  <= wgt_rd_en_d;
            o_wgt_addr   <= wgt_addr_d;
            o_load       <= load_d;
            o_fmap_rd_en <= fmap_rd_en_d;
            o_fmap_addr  <= fmap_addr_d;
        end
    end

    assign run = (state == S_RUN);

    // Row r: 1-cycle SRAM latency plus r-cycle skew. Column c: N more cycles through the array.
    for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
        ws_window_gen #(.CW(CW), .LEN_W(LEN_W)) u_win (
            .clk(clk), .rstn(rstn), .en(run), .cnt(cnt),
            .base(CW'(1 + r)), .num(num), .in_window(o_row_en[r])
        );
    end

    for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col
        ws_window_gen #(.CW(CW), .LEN_W(LEN_W)) u_win (
            .clk(clk), .rstn(rstn), .en(run), .cnt(cnt),
            .base(CW'(1 + ARRAY_SIZE + c)), .num(num), .in_window(o_col_valid[c])
        );
    end

endmodule

// File: tb/tb_ws_array_controller.sv
// Self-checking bench: a timeline model of the sequencer, derived from start-relative
// cycle offsets, compared every cycle, plus directed scenario checks.
module tb_ws_array_controller;

    localparam int N    = 4;
    localparam int LW   = 8;
    localparam int AW   = 2;
    localparam int MAXK = 700;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          i_start = 1'b0;
    logic [LW-1:0] i_num_vec = '0;
    logic          o_busy, o_done, o_wgt_rd_en, o_load, o_fmap_rd_en;
    logic [AW-1:0] o_wgt_addr;
    logic [LW-1:0] o_fmap_addr;
    logic [N-1:0]  o_row_en, o_col_valid;

    ws_array_controller #(.DATA_WIDTH(8), .ARRAY_SIZE(N), .LEN_W(LW)) dut (
        .clk(clk), .rstn(rstn), .i_start(i_start), .i_num_vec(i_num_vec),
        .o_busy(o_busy), .o_done(o_done), .o_wgt_rd_en(o_wgt_rd_en),
        .o_wgt_addr(o_wgt_addr), .o_load(o_load), .o_fmap_rd_en(o_fmap_rd_en),
        .o_fmap_addr(o_fmap_addr), .o_row_en(o_row_en), .o_col_valid(o_col_valid)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: j = edges since start acceptance; everything follows from j, M and N.
    bit m_active = 1'b0;
    int m_j = 0, m_num = 0, m_total = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_active <= 1'b0;
            m_j      <= 0;
        end else if (m_active) begin
            m_j <= m_j + 1;
            if (m_j + 1 > m_total) m_active <= 1'b0;
        end else if (i_start) begin
            m_active <= 1'b1;
            m_j      <= 0;
            m_num    <= int'(i_num_vec);
            m_total  <= (i_num_vec != '0) ? 3 * N + int'(i_num_vec) + 2 : N + 2;
        end
    end

    always @(negedge clk) begin
        int c;
        bit run, e_wrd, e_frd;
        logic [N-1:0] e_row, e_col;
        if (rstn) begin
            c     = m_j - N - 2;
            run   = m_active && m_num > 0 && c >= 0 && c < m_num + 2 * N;
            e_wrd = m_active && m_j >= 1 && m_j <= N;
            e_frd = run && c < m_num;
            for (int r = 0; r < N; r++) begin
                e_row[r] = run && c >= 1 + r && c < 1 + r + m_num;
                e_col[r] = run && c >= 1 + N + r && c < 1 + N + r + m_num;
            end
            check("busy", o_busy, m_active && m_j >= 1 && m_j <= m_total - 1);
            check("done", o_done, m_active && m_j == m_total);
            check("wgt_rd_en", o_wgt_rd_en, e_wrd);
            check("wgt_addr", o_wgt_addr, e_wrd ? N - m_j : 0);
            check("load", o_load, m_active && m_j >= 2 && m_j <= N + 1);
            check("fmap_rd_en", o_fmap_rd_en, e_frd);
            check("fmap_addr", o_fmap_addr, e_frd ? c : 0);
            check("row_en", o_row_en, e_row);
            check("col_valid", o_col_valid, e_col);
        end
    end

    // Per-operation observations used by the directed checks.
    int lat, n_wgt, first_wgt, n_load, first_load, last_load;
    int n_fmap, first_fmap, last_fmap, n_row2, first_row2, last_row2, last_col3;
    bit fmap_contig, seen;
    int wgt_addr_q[$];

    task automatic run_op(input int m, input int pa, input int pb, input int pc,
                          input bit rnd, input int rst_k);
        lat = -1; n_wgt = 0; first_wgt = -1; n_load = 0; first_load = -1; last_load = -1;
        n_fmap = 0; first_fmap = -1; last_fmap = -1; n_row2 = 0; first_row2 = -1;
        last_row2 = -1; last_col3 = -1; fmap_contig = 1'b1; seen = 1'b0;
        wgt_addr_q.delete();
        @(negedge clk);
        i_start   = 1'b1;
        i_num_vec = LW'(m);
        @(negedge clk);
        i_start = 1'b0;
        for (int k = 1; k <= MAXK; k++) begin
            @(negedge clk);
            i_start = (k == pa) || (k == pb) || (k == pc) || (rnd && $urandom_range(0, 5) == 0);
            if (rnd && i_start) i_num_vec = LW'($urandom);
            if (o_wgt_rd_en) begin
                if (n_wgt == 0) first_wgt = k;
                wgt_addr_q.push_back(int'(o_wgt_addr));
                n_wgt++;
            end
            if (o_load) begin
                if (n_load == 0) first_load = k;
                last_load = k;
                n_load++;
            end
            if (o_fmap_rd_en) begin
                if (n_fmap == 0) first_fmap = k;
                if (int'(o_fmap_addr) != n_fmap) fmap_contig = 1'b0;
                last_fmap = k;
                n_fmap++;
            end
            if (o_row_en[2]) begin
                if (n_row2 == 0) first_row2 = k;
                last_row2 = k;
                n_row2++;
            end
            if (o_col_valid[N-1]) last_col3 = k;
            if (k == rst_k) begin
                i_start = 1'b0;
                #2 rstn = 1'b0;
                #1 check("async_reset_outputs",
                         {o_busy, o_done, o_wgt_rd_en, o_wgt_addr, o_load, o_fmap_rd_en,
                          o_fmap_addr, o_row_en, o_col_valid}, 0);
                repeat (3) @(negedge clk);
                rstn = 1'b1;
                break;
            end
            if (o_done) begin
                lat  = k;
                seen = 1'b1;
                break;
            end
        end
        if (rst_k < 0) check("done_seen", seen, 1);
    endtask

    task automatic count_dones(input int cycles, output int dones);
        dones = 0;
        repeat (cycles) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_done) dones++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dones, m;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {o_busy, o_done, o_wgt_rd_en, o_wgt_addr, o_load, o_fmap_rd_en,
               o_fmap_addr, o_row_en, o_col_valid}, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Full run, N=4, M=16.
        run_op(16, -1, -1, -1, 1'b0, -1);
        check("latency_m16", lat, 30);
        check("wgt_reads", n_wgt, 4);
        check("first_wgt_cycle", first_wgt, 1);
        for (int i = 0; i < wgt_addr_q.size(); i++) check("wgt_addr_seq", wgt_addr_q[i], 3 - i);
        check("load_count", n_load, 4);
        check("load_lag", first_load - first_wgt, 1);
        check("load_span", last_load - first_load, 3);
        check("fmap_count", n_fmap, 16);
        check("fmap_contig", fmap_contig, 1);
        check("fmap_span", last_fmap - first_fmap, 15);
        check("row2_count", n_row2, 16);
        check("row2_offset", first_row2 - first_fmap, 3);
        check("row2_span", last_row2 - first_row2, 15);
        check("col3_end", last_col3, lat - 1);

        // Zero length.
        run_op(0, -1, -1, -1, 1'b0, -1);
        check("latency_m0", lat, 6);
        check("wgt_reads_m0", n_wgt, 4);
        check("fmap_reads_m0", n_fmap, 0);
        check("col3_m0", last_col3, -1);

        // Starts in WLOAD, in DONE and during the done pulse are all ignored.
        run_op(3, 2, 16, 17, 1'b0, -1);
        check("latency_m3_pokes", lat, 17);
        count_dones(30, dones);
        check("extra_dones", dones, 0);
        run_op(3, 2, 16, -1, 1'b0, -1);
        check("latency_m3_pokes2", lat, 17);
        run_op(3, -1, -1, -1, 1'b0, -1);
        check("latency_back_to_back", lat, 17);

        // Reset mid-RUN at cnt=10: outputs drop at once, no done afterwards.
        run_op(16, -1, -1, -1, 1'b0, N + 2 + 10);
        count_dones(40, dones);
        check("dones_after_reset", dones, 0);
        run_op(5, -1, -1, -1, 1'b0, -1);
        check("latency_after_reset", lat, 3 * N + 5 + 2);

        // Randomized operations with stray start requests.
        repeat (40) begin
            m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
            run_op(m, -1, -1, -1, 1'b1, -1);
            check("latency_rand", lat, (m > 0) ? 3 * N + m + 2 : N + 2);
            check("fmap_reads_rand", n_fmap, m);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                i_start = 1'b0;
            end
        end

        @(negedge clk);
        i_start = 1'b0;
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ws_array_controller.md
# ws_array_controller

Sequencer for the weight-stationary N×N `processing_element` array. On a start pulse it first loads one weight tile into the array through the PE `i_load`/`o_weight` chain. It then streams M feature-map vectors from the fmap buffer and generates per-row skew enables and per-column output-valid strobes. It sits between the weight/fmap SRAM read ports and the array's skew and deskew register banks; it touches no data, only addresses, enables and strobes.

## Interface
- `DATA_WIDTH`, 8, PE operand width; used only for package consistency.
- `ARRAY_SIZE`, 4, N: array rows and columns; must be ≥2.
- `LEN_W`, 8, width of the vector count M; requires 2·N ≤ 2^LEN_W.
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  one-cycle start request; honoured only in IDLE.
- `i_num_vec`  in  LEN_W  M, number of fmap vectors; sampled when `i_start` is accepted.
- `o_busy`  out  1  high in WLOAD and RUN.
- `o_done`  out  1  one-cycle completion pulse.
- `o_wgt_rd_en`  out  1  weight SRAM read enable; SRAM read latency is 1 cycle.
- `o_wgt_addr`  out  clog2(N)  weight row index.
- `o_load`  out  1  drives every PE `i_load`.
- `o_fmap_rd_en`  out  1  fmap SRAM read enable; read latency is 1 cycle.
- `o_fmap_addr`  out  LEN_W  fmap vector index.
- `o_row_en`  out  N  bit r: row r skew register accepts data this cycle.
- `o_col_valid`  out  N  bit c: column c bottom `o_psum` is a valid result this cycle.

## Operation
- The FSM has states IDLE, WLOAD, RUN, DONE. Reset forces IDLE with every output and counter at 0.
- IDLE:
  - `i_start`=1 latches M (`i_num_vec`), clears the counter `w`, and moves to WLOAD.
  - `i_start` in any other state is ignored; it is not queued.
- WLOAD counts `w` = 0..N.
  - `o_wgt_rd_en`=1 for w<N, with `o_wgt_addr` = N−1−w, so the bottom row is fetched first and shifts furthest down the chain.
  - `o_load`=1 for w=1..N, aligned with SRAM data.
  - At w=N: if M=0, go to DONE; otherwise go to RUN with `cnt`=0.
- RUN counts `cnt` = 0..M+2N−1. The counter is LEN_W+1 bits.
  - `o_fmap_rd_en`=1 and `o_fmap_addr`=`cnt` for cnt<M.
  - `o_row_en[r]`=1 for 1+r ≤ cnt < 1+r+M. This covers the 1-cycle SRAM latency plus an r-cycle skew.
  - `o_col_valid[c]`=1 for 1+N+c ≤ cnt < 1+N+c+M. This covers the horizontal fmap hop c, N−1 vertical hops, and the PE psum register.
  - At cnt = M+2N−1 (the last `o_col_valid[N−1]` cycle), go to DONE.
- DONE lasts one cycle: `o_done`=1, `o_busy`=0, then IDLE. A start in DONE is ignored.
- M=0 still loads weights and still pulses done; no fmap reads and no valids are issued.
- Maximum M is 2^LEN_W−1. Counter comparisons are unsigned, with no wrap: `cnt` never exceeds M+2N−1.
- Reset mid-operation aborts immediately. No done pulse is produced; SRAM enables drop asynchronously.

## Timing
- All outputs are registered (Moore) and are 0 at reset.
- Start accepted at edge S:
  - WLOAD occupies edges S+1..S+N+1.
  - `o_busy` rises after edge S+1.
  - The first `o_wgt_rd_en` is the cycle after the edge S+1.
- Total latency from start acceptance to `o_done`:
  - M>0: N+1 (WLOAD) + M+2N (RUN) + 1 cycles.
  - M=0: N+2 cycles.
- Back-to-back operation: the earliest next start is the cycle after `o_done`, i.e. in IDLE.
- `o_row_en` and `o_col_valid` bits are contiguous M-cycle windows. For any bit, the window is offset exactly +1 cycle from the preceding bit.

## Structure
- Shared package `ws_pkg` holds:
  - the state encoding (IDLE=0, WLOAD=1, RUN=2, DONE=3);
  - the `DATA_WIDTH` and `ARRAY_SIZE` defaults;
  - the clog2 helper.
- One sub-module, `ws_window_gen`, generated N times for rows and N times for columns.
  - Inputs: `cnt`, a base offset, and M.
  - Output: a registered `in_window` bit.

## Test plan
- Reset mid-RUN (N=4, M=16): assert `rstn`=0 at cnt=10 → all outputs 0 asynchronously; FSM in IDLE after release; no `o_done`.
- Weight load (N=4, M=16): start → `o_wgt_addr` 3,2,1,0 on 4 consecutive cycles; `o_load` high for 4 cycles, each lagging its read by 1.
- Stream windows (N=4, M=16):
  - `o_fmap_addr` 0..15 contiguous;
  - `o_row_en[2]` high for exactly 16 cycles, starting 3 cycles after the first fmap read;
  - `o_col_valid[3]` ends on the cycle before `o_done`.
- Total latency (N=4, M=16): `o_done` exactly 5+24+1 = 30 cycles after start acceptance.
- Zero length (N=4, M=0): 4 weight reads, no fmap reads, `o_done` 6 cycles after start.
- Start while busy (N=4, M=3): second `i_start` at WLOAD w=2 and again in DONE → ignored; exactly one `o_done`; a start one cycle after `o_done` runs normally.
